lsu_seq: RTL and testbench
==========================

# lsu_seq

Load/store sequencer for the NPC core. It takes the decoder's memory-access controls for the current instruction and runs one transaction on the data-memory bus. It aligns store data and strobes, and sign- or zero-extends load data. It also generates `mem_finish`, the one-cycle completion pulse that gates register-file and CSR writeback for every instruction. It sits between the decoder/ALU (address, store data) and the data-memory port.

## Interface
- `ADDR_W`, 64: address width.
- `XLEN`, 64: data width; the bus is `XLEN` bits wide and 8-byte aligned.

- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `inst_update`  in  1  one-cycle pulse: decoder outputs for a new instruction are valid.
- `data_ram_en`  in  1  instruction is a load.
- `data_ram_wen`  in  1  instruction is a store.
- `l_choose`  in  7  one-hot load kind: bit0 ld, bit1 lw, bit2 lwu, bit3 lh, bit4 lhu, bit5 lb, bit6 lbu.
- `wmask`  in  8  store byte mask, unshifted: 0x01 sb, 0x03 sh, 0x0F sw, 0xFF sd.
- `addr`  in  ADDR_W  effective address (ALU result).
- `wdata`  in  XLEN  store data (rs2), unshifted.
- `req_valid`  out  1  bus request valid.
- `req_ready`  in  1  bus accepts request.
- `req_wen`  out  1  1 = write.
- `req_addr`  out  ADDR_W  `addr` with bits [2:0] cleared.
- `req_wdata`  out  XLEN  `wdata << 8*addr[2:0]`.
- `req_wstrb`  out  8  `wmask << addr[2:0]`; 0 for reads.
- `resp_valid`  in  1  read data or write acknowledge valid.
- `resp_rdata`  in  XLEN  read data, 8-byte aligned.
- `resp_ready`  out  1  high exactly in state RESP.
- `mem_finish`  out  1  one-cycle completion pulse.
- `load_data`  out  XLEN  extended load result.
- `mem_err`  out  1  misaligned access; valid with `mem_finish`.

## Operation
- `start` = `inst_update` & (`data_ram_en` | `data_ram_wen`), sampled only in IDLE.
- States and transitions:
  - IDLE → REQ on `start`. On entry, latch `addr`, `wdata`, `wmask`, `l_choose` and direction. `data_ram_wen` has priority if both enables are set.
  - REQ: hold `req_valid`=1 with stable fields. On `req_valid`&`req_ready`, go to RESP.
  - RESP: `resp_ready`=1. On `resp_valid`, go to DONE; for a load, register `load_data`.
  - DONE: `mem_finish`=1 for one cycle, then go to IDLE.
  - ERR: `mem_finish`=1 and `mem_err`=1 for one cycle, then go to IDLE.
- Misalignment check at latch time: `addr[2:0]` + size > 8 → IDLE → ERR; no bus request is issued.
  - Load size: 8/4/4/2/2/1/1 per `l_choose` bit.
  - Store size: popcount(`wmask`).
- Non-memory instruction: `mem_finish` = `inst_update` combinationally in IDLE (same cycle), `mem_err`=0. No state change.
- Load extension, after `sh = resp_rdata >> 8*addr[2:0]`:
  - ld: `sh`.
  - lw: sext(`sh[31:0]`); lwu: zext(`sh[31:0]`).
  - lh: sext(`sh[15:0]`); lhu: zext(`sh[15:0]`).
  - lb: sext(`sh[7:0]`); lbu: zext(`sh[7:0]`).
- `load_data` holds its value until the next load completes. Stores and errors do not change it.
- `inst_update` outside IDLE is ignored.
- The write response carries no data; `resp_rdata` is ignored for stores.

## Timing
- Reset values: state IDLE; `req_valid`, `req_wen`, `resp_ready`, `mem_finish`, `mem_err` = 0; `req_wstrb` = 0; `req_addr`, `req_wdata`, `load_data` = 0.
- Minimum latency (zero-wait bus):
  - cycle T: `inst_update` with a memory op.
  - T+1: REQ, `req_valid` high.
  - T+2: RESP.
  - T+3: DONE, `mem_finish` high, `load_data` valid.
  - T+4: IDLE; a new `start` is accepted here.
- Each `req_ready` wait cycle and each `resp_valid` wait cycle adds exactly one cycle.
- Misaligned access: `mem_finish`+`mem_err` at T+1.
- `req_ready` is sampled only in REQ; `resp_valid` is sampled only in RESP. A `resp_valid` in the same cycle as the request handshake is not accepted.
- `rst` in any state returns to IDLE on the next edge:
  - the pending request is dropped (`req_valid` falls in the same cycle);
  - no `mem_finish` is generated for the aborted access.
- Exactly one `mem_finish` pulse per `inst_update` accepted in IDLE.

## Test plan
- Non-memory op: pulse `inst_update` with both enables 0 → `mem_finish`=1 in the same cycle, `req_valid` never rises.
- lw, zero-wait: addr=0x80000004, `resp_rdata`=0x8765_4321_0000_0000 → `req_addr`=0x80000000, `req_wstrb`=0; `load_data`=0xFFFF_FFFF_8765_4321 with `mem_finish` at T+3.
- lbu vs lb: addr=...7, `resp_rdata[63:56]`=0x9C → lbu gives 0x9C; lb gives 0xFFFF_FFFF_FFFF_FF9C.
- sh, backpressure: addr=...2, wdata=0xBEEF, `req_ready` low for 3 cycles → fields stable throughout; `req_wstrb`=0x0C, `req_wdata`=0xBEEF_0000, `req_wen`=1; `mem_finish` at T+6.
- Misaligned sw: addr=...6 → no `req_valid`; `mem_finish`=`mem_err`=1 at T+1; `load_data` unchanged.
- Reset mid-RESP: assert `rst` while waiting for `resp_valid` → next cycle IDLE, all outputs at reset values, no `mem_finish`; a following ld completes normally.

Source files
------------

// File: rtl/lsu_seq.sv
// lsu_seq: runs one data-memory transaction per load/store instruction, aligning
// store data/strobes, extending load data and pulsing mem_finish on completion.
module lsu_seq #(
    parameter int ADDR_W = 64,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_update,
    input  logic              data_ram_en,
    input  logic              data_ram_wen,
    input  logic [6:0]        l_choose,
    input  logic [7:0]        wmask,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wen,
    output logic [ADDR_W-1:0] req_addr,
    output logic [XLEN-1:0]   req_wdata,
    output logic [7:0]        req_wstrb,
    input  logic              resp_valid,
    input  logic [XLEN-1:0]   resp_rdata,
    output logic              resp_ready,
    output logic              mem_finish,
    output logic [XLEN-1:0]   load_data,
    output logic              mem_err
);
    typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, ERR} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q, load_q, sh, ext;
    logic [7:0]        wstrb_q;
    logic [6:0]        lch_q;
    logic [2:0]        off_q;
    logic              wen_q, start, misal;
    logic [3:0]        size;
    assign start = inst_update & (data_ram_en | data_ram_wen);
    assign size  = data_ram_wen ? 4'($countones(wmask))
                 : l_choose[0] ? 4'd8
                 : |l_choose[2:1] ? 4'd4
                 : |l_choose[4:3] ? 4'd2 : 4'd1;
    assign misal = ({2'b00, addr[2:0]} + {1'b0, size}) > 5'd8;
    assign sh    = resp_rdata >> {off_q, 3'b000};
    assign ext   = lch_q[0] ? sh
                 : lch_q[1] ? {{(XLEN-32){sh[31]}}, sh[31:0]}
                 : lch_q[2] ? {{(XLEN-32){1'b0}}, sh[31:0]}
                 : lch_q[3] ? {{(XLEN-16){sh[15]}}, sh[15:0]}
                 : lch_q[4] ? {{(XLEN-16){1'b0}}, sh[15:0]}
                 : lch_q[5] ? {{(XLEN-8){sh[7]}}, sh[7:0]}
                 : lch_q[6] ? {{(XLEN-8){1'b0}}, sh[7:0]} : sh;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            load_q  <= '0;
            lch_q   <= '0;
            off_q   <= '0;
            wen_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    addr_q  <= {addr[ADDR_W-1:3], 3'b000};
                    wdata_q <= wdata << {addr[2:0], 3'b000};
                    wstrb_q <= data_ram_wen ? wmask << addr[2:0] : 8'h00;
                    lch_q   <= l_choose;
                    off_q   <= addr[2:0];
                    wen_q   <= data_ram_wen;
                    state_q <= misal ? ERR : REQ;
                end
                REQ:  if (req_ready) state_q <= RESP;
                RESP: if (resp_valid) begin
                    state_q <= DONE;
                    if (!wen_q) load_q <= ext;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // req_valid drops in the reset cycle itself so an aborted request is never handshaken
    assign req_valid  = (state_q == REQ) & ~rst;
    assign req_wen    = wen_q;
    assign req_addr   = addr_q;
    assign req_wdata  = wdata_q;
    assign req_wstrb  = wstrb_q;
    assign resp_ready = state_q == RESP;
    assign load_data  = load_q;
    assign mem_err    = state_q == ERR;
    assign mem_finish = (state_q == DONE) | (state_q == ERR)
                      | ((state_q == IDLE) & inst_update & ~data_ram_en & ~data_ram_wen & ~rst);
endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: randomized scoreboard bench for lsu_seq with a byte-level reference model
// and a bus responder that injects request/response wait states.
module tb_lsu_seq;
    logic        clk = 0, rst = 1;
    logic        inst_update = 0, data_ram_en = 0, data_ram_wen = 0;
    logic [6:0]  l_choose = 0;
    logic [7:0]  wmask = 0;
    logic [63:0] addr = 0, wdata = 0;
    logic        req_valid, req_ready = 0, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid = 0;
    logic [63:0] resp_rdata = 0;
    logic        resp_ready, mem_finish, mem_err;
    logic [63:0] load_data;

    lsu_seq dut (
        .clk(clk), .rst(rst), .inst_update(inst_update), .data_ram_en(data_ram_en),
        .data_ram_wen(data_ram_wen), .l_choose(l_choose), .wmask(wmask), .addr(addr),
        .wdata(wdata), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ready(resp_ready),
        .mem_finish(mem_finish), .load_data(load_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; bit err; logic [63:0] ld;} fin_t;
    typedef struct {int dr; int dv; logic [63:0] rdata; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wstrb; bit wen;} bus_t;
    fin_t sb[$];
    bus_t bq[$];
    logic [63:0] model_ld = 0;
    int vectors = 0, miscompares = 0;
    bit auto_bus = 1;
    int sz_tab[7] = '{8, 4, 4, 2, 2, 1, 1};
    bit sg_tab[7] = '{0, 1, 0, 1, 0, 1, 0};

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction in the current (IDLE) cycle and wait for its completion.
    task automatic do_op(bit en, bit wen, logic [6:0] lc, logic [7:0] wm, logic [63:0] a,
                         logic [63:0] wd, logic [63:0] rd, int dr, int dv);
        int off = int'(a[2:0]);
        int size = 0;
        bit sg = 0;
        bit mem = en | wen;
        bit err;
        fin_t f;
        bus_t b;
        if (wen) begin
            for (int i = 0; i < 8; i++) size += int'(wm[i]);
        end else begin
            for (int i = 0; i < 7; i++) if (lc[i]) begin size = sz_tab[i]; sg = sg_tab[i]; end
        end
        err = mem && (off + size > 8);
        b.addr = a & ~64'h7; b.wdata = 0; b.wstrb = 0; b.wen = wen;
        b.dr = dr; b.dv = dv; b.rdata = rd;
        if (mem && !err && wen) begin
            for (int k = off; k < 8; k++) begin
                b.wstrb[k] = wm[k-off];
                b.wdata[8*k +: 8] = wd[8*(k-off) +: 8];
            end
        end
        if (mem && !err && !wen) begin
            logic [63:0] v = 0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
            if (sg && v[8*size-1]) for (int j = 8*size; j < 64; j++) v[j] = 1'b1;
            model_ld = v;
        end
        f.cyc = cyc + (!mem ? 0 : err ? 1 : 3 + dr + dv);
        f.err = err;
        f.ld  = model_ld;
        sb.push_back(f);
        if (mem && !err) bq.push_back(b);
        inst_update = 1; data_ram_en = en; data_ram_wen = wen;
        l_choose = lc; wmask = wm; addr = a; wdata = wd;
        nxt();
        inst_update = 0;
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        if (mem) begin
            // a stray instruction pulse while busy must be ignored
            if ($urandom_range(1, 0) == 1) begin
                inst_update = 1;
                data_ram_en = 1'($urandom);
                data_ram_wen = 1'($urandom);
            end
            nxt();
            inst_update = 0;
        end
        for (int i = 0; i < 60 && sb.size() != 0; i++) nxt();
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL completion_timeout got=no mem_finish want=mem_finish at cycle %0d", f.cyc);
            sb.delete();
            bq.delete();
        end
    endtask

    // completion monitor / scoreboard
    initial begin
        fin_t f;
        forever begin
            @(negedge clk);
            if (mem_finish) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_finish got=1 want=0 (cycle %0d)", cyc);
                end else begin
                    f = sb.pop_front();
                    chk("finish_cycle", 64'(cyc), 64'(f.cyc));
                    chk("mem_err", 64'(mem_err), 64'(f.err));
                    chk("load_data", load_data, f.ld);
                end
            end
        end
    end

    // bus responder: checks request fields and plays the scripted wait states
    initial begin
        bus_t b;
        forever begin
            @(negedge clk);
            if (auto_bus && req_valid) begin
                if (bq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_req got=1 want=0 (cycle %0d)", cyc);
                end else begin
                    b = bq.pop_front();
                    for (int k = 0; k <= b.dr; k++) begin
                        if (k > 0) @(negedge clk);
                        chk("req_valid", 64'(req_valid), 64'd1);
                        chk("req_addr", req_addr, b.addr);
                        chk("req_wstrb", 64'(req_wstrb), 64'(b.wstrb));
                        chk("req_wen", 64'(req_wen), 64'(b.wen));
                        if (b.wen) chk("req_wdata", req_wdata, b.wdata);
                        if (k == b.dr) begin
                            req_ready = 1;
                            resp_valid = 1;
                            resp_rdata = ~b.rdata;
                        end
                    end
                    @(negedge clk);
                    req_ready = 0;
                    for (int k = 0; k <= b.dv; k++) begin
                        if (k > 0) @(negedge clk);
                        chk("resp_ready", 64'(resp_ready), 64'd1);
                        resp_valid = (k == b.dv);
                        resp_rdata = (k == b.dv) ? b.rdata : {$urandom, $urandom};
                    end
                    @(negedge clk);
                    resp_valid = 0;
                end
            end
        end
    end

    task automatic chk_reset_vals(string tag);
        chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        chk({tag, "_req_wen"}, 64'(req_wen), 64'd0);
        chk({tag, "_resp_ready"}, 64'(resp_ready), 64'd0);
        chk({tag, "_mem_finish"}, 64'(mem_finish), 64'd0);
        chk({tag, "_mem_err"}, 64'(mem_err), 64'd0);
        chk({tag, "_req_wstrb"}, 64'(req_wstrb), 64'd0);
        chk({tag, "_req_addr"}, req_addr, 64'd0);
        chk({tag, "_req_wdata"}, req_wdata, 64'd0);
        chk({tag, "_load_data"}, load_data, 64'd0);
    endtask

    initial begin
        logic [7:0] wm_tab[4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk_reset_vals("reset");
        nxt();
        // directed cases
        do_op(0, 0, 7'h00, 8'h00, 64'h1234, 64'h55, 64'h0, 0, 0);
        do_op(1, 0, 7'b0000010, 8'h00, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0);
        chk("lw_value", load_data, 64'hFFFF_FFFF_8765_4321);
        do_op(1, 0, 7'b1000000, 8'h00, 64'h1007, 64'h0, 64'h9C00_0000_0000_0000, 1, 2);
        chk("lbu_value", load_data, 64'h9C);
        do_op(1, 0, 7'b0100000, 8'h00, 64'h1007, 64'h0, 64'h9C11_2233_4455_6677, 0, 1);
        chk("lb_value", load_data, 64'hFFFF_FFFF_FFFF_FF9C);
        do_op(0, 1, 7'h00, 8'h03, 64'h2002, 64'hBEEF, 64'h0, 3, 0);
        do_op(0, 1, 7'h00, 8'h0F, 64'h3006, 64'h1111_2222, 64'h0, 0, 0);
        chk("misaligned_load_data_held", load_data, 64'hFFFF_FFFF_FFFF_FF9C);
        do_op(1, 1, 7'b0000001, 8'h01, 64'h4005, 64'hA5, 64'h0, 0, 0);
        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            int k = $urandom_range(99, 0);
            bit en = (k >= 20 && k < 55) || k >= 95;
            bit wen = k >= 55;
            logic [63:0] a = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 1) a[2:0] = 3'b000;
            do_op(en, wen, 7'(1 << $urandom_range(6, 0)), wm_tab[$urandom_range(3, 0)], a,
                  {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(3, 0), $urandom_range(3, 0));
            for (int g = $urandom_range(2, 0); g > 0; g--) nxt();
        end
        // reset while waiting for the response
        auto_bus = 0;
        inst_update = 1; data_ram_en = 1; data_ram_wen = 0; l_choose = 7'b0000001; addr = 64'h3000;
        nxt();
        inst_update = 0; req_ready = 1;
        nxt();
        req_ready = 0;
        @(negedge clk);
        chk("rst_pre_resp_ready", 64'(resp_ready), 64'd1);
        nxt();
        rst = 1;
        nxt();
        rst = 0;
        model_ld = 0;
        @(negedge clk);
        chk_reset_vals("rst_resp");
        nxt();
        // reset while a request is pending: req_valid drops at once
        inst_update = 1; data_ram_en = 0; data_ram_wen = 1; wmask = 8'hFF; addr = 64'h5000;
        nxt();
        inst_update = 0;
        @(negedge clk);
        chk("req_valid_before_rst", 64'(req_valid), 64'd1);
        nxt();
        rst = 1;
        @(negedge clk);
        chk("req_valid_in_rst", 64'(req_valid), 64'd0);
        nxt();
        rst = 0;
        auto_bus = 1;
        nxt();
        do_op(1, 0, 7'b0000001, 8'h00, 64'h6008, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 1);
        chk("ld_after_rst", load_data, 64'h0123_4567_89AB_CDEF);
        repeat (3) nxt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
